if_inst_queue: RTL
==================

// Module: if_inst_queue
// PURPOSE
//  Instruction fetch queue between ifu (producer) and id (consumer).
//  - Buffers fetched {pc, instruction} pairs so a stalled id does not drop fetches from ifu.
//  - Uses valid/ready handshakes on both sides.
//  - Provides a flush for branch/jump redirect.
// PARAMETERS
//  DEPTH  4   number of entries; power of two, >=2
//  AW     2   pointer width, log2(DEPTH)
//  DW     32  width of the pc field and of the instruction field
// PORTS
//  clk          in   1    core clock; all state updates on its rising edge
//  rst_n        in   1    synchronous active-low reset
//  flush_i      in   1    discard all entries (redirect)
//  push_valid_i in   1    ifu presents an instruction
//  push_pc_i    in   DW   pc of the pushed instruction
//  push_inst_i  in   DW   pushed instruction word
//  push_ready_o out  1    queue can accept; equals !full
//  pop_valid_o  out  1    head entry valid toward id
//  pop_pc_o     out  DW   pc of the head entry
//  pop_inst_o   out  DW   instruction of the head entry
//  pop_ready_i  in   1    id accepts the head entry
//  count_o      out  AW+1 number of occupied entries, 0..DEPTH
// BEHAVIOUR
//  - Reset (rst_n==0 at a clk edge):
//    - wr_ptr, rd_ptr and count cleared to 0.
//    - Outputs: pop_valid_o=0, push_ready_o=1, count_o=0.
//    - pop_pc_o and pop_inst_o read as 0 while empty.
//  - Transfer rules:
//    - Push transfer: push_valid_i && push_ready_o at a clk edge. Entry written at wr_ptr; wr_ptr advances.
//    - Pop transfer: pop_valid_o && pop_ready_i at a clk edge. rd_ptr advances.
//    - pop_valid_o, pop_pc_o and pop_inst_o are driven from registered storage.
//  - Pointers: wrap modulo DEPTH. count = written minus popped, kept at AW+1 bits.
//  - Full/empty:
//    - full  = (count==DEPTH) -> push_ready_o=0; a push is ignored and the caller holds its data.
//    - empty = (count==0)     -> pop_valid_o=0; pop_ready_i is ignored.
//  - Simultaneous push and pop in one cycle: both occur and count is unchanged.
//    - When full, push_ready_o stays 0 even if a pop occurs in the same cycle. No combinational ready-through.
//  - Latency: a pushed entry appears on pop_* one cycle after the push edge (empty queue, no bypass).
//  - Ordering: strict FIFO. pop_* must stay stable while pop_valid_o && !pop_ready_i.
//  - Flush:
//    - flush_i=1 at an edge clears pointers and count; any push or pop in that cycle is discarded.
//    - Next cycle: pop_valid_o=0, push_ready_o=1.
//    - Priority: rst_n > flush_i > push/pop.
//  - Reset mid-operation: all entries are lost, same as flush.
//  - Storage contents are not reset; only pointers and count are.
// CONFIGURATION
//  IFQ_BYPASS_EN
//  - Defined:
//    - When the queue is empty and push_valid_i=1, pop_valid_o/pop_pc_o/pop_inst_o are driven combinationally from push_*.
//    - If pop_ready_i=1 in that cycle, the entry is consumed without being written; count stays 0.
//    - If pop_ready_i=0, the entry is written normally.
//    - Zero-cycle latency when empty.
//  - Undefined: pop_* are purely registered; minimum latency is 1 cycle.
//  - Flush still has priority: with flush_i=1, bypass output is suppressed (pop_valid_o=0).
// TESTING
//  1. Reset, then 4 pushes {pc 0x0,0x4,0x8,0xC; inst 0x00000013+i}, pop_ready_i=0
//     -> count_o=4, push_ready_o=0; a 5th push is not accepted.
//  2. From full, pop_ready_i=1 for 4 cycles
//     -> pop_pc_o sequence 0x0,0x4,0x8,0xC in order; count_o goes to 0; pop_valid_o=0 afterwards.
//  3. Continuous push and pop for 10 cycles with pc stepping by 4
//     -> count_o stays 1 (stays 0 with IFQ_BYPASS_EN); pointers wrap; no loss or reorder.
//  4. Queue holding 3 entries, assert flush_i together with push_valid_i=1
//     -> next cycle count_o=0, pop_valid_o=0; pushed pc 0x10 never appears on pop_*.
//  5. Stall: head pc 0x20 held with pop_ready_i=0 for 5 cycles
//     -> pop_pc_o/pop_inst_o remain constant; pop occurs on the cycle pop_ready_i=1.
//  6. Drive rst_n=0 for one cycle mid-stream while count=2
//     -> next cycle count_o=0, pop_valid_o=0, push_ready_o=1.

Source files
------------

// File: rtl/if_inst_queue_if.sv
// Handshake bundle between ifu (master) and the instruction queue (slave), plus the
// redirect flush and the occupancy count.
interface if_inst_queue_if #(
  parameter int unsigned AW = 2,
  parameter int unsigned DW = 32
);
  logic          flush;
  logic          push_valid;
  logic [DW-1:0] push_pc;
  logic [DW-1:0] push_inst;
  logic          push_ready;
  logic          pop_valid;
  logic [DW-1:0] pop_pc;
  logic [DW-1:0] pop_inst;
  logic          pop_ready;
  logic [AW:0]   count;

  modport master (
    output flush, push_valid, push_pc, push_inst, pop_ready,
    input  push_ready, pop_valid, pop_pc, pop_inst, count
  );

  modport slave (
    input  flush, push_valid, push_pc, push_inst, pop_ready,
    output push_ready, pop_valid, pop_pc, pop_inst, count
  );
endinterface

// File: rtl/if_inst_queue.sv
// Instruction fetch queue: FIFO of {pc, inst} pairs between ifu and id with flush.
// Optional macro IFQ_BYPASS_EN gives a zero-latency path from push to pop when empty.
module if_inst_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2,
  parameter int unsigned DW    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  if_inst_queue_if.slave    q
);

  logic [DW-1:0] pc_mem   [DEPTH];
  logic [DW-1:0] inst_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;

  logic full;
  logic empty;
  logic bypass_c;
  logic push_fire;
  logic pop_fire;
  logic do_write;
  logic do_read;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);

`ifdef IFQ_BYPASS_EN
  assign bypass_c = empty && q.push_valid && !q.flush;
`else
  assign bypass_c = 1'b0;
`endif

  // Ready depends only on registered occupancy: no ready-through when full.
  assign q.push_ready = !full;
  assign q.count      = count_q;

  assign push_fire = q.push_valid && !full;
  assign pop_fire  = (!empty || bypass_c) && q.pop_ready;
  // A bypassed entry consumed in the same cycle is never stored.
  assign do_write  = push_fire && !(bypass_c && q.pop_ready);
  assign do_read   = pop_fire && !bypass_c;

  always_comb begin
    q.pop_valid = 1'b0;
    q.pop_pc    = '0;
    q.pop_inst  = '0;
    if (!empty) begin
      q.pop_valid = 1'b1;
      q.pop_pc    = pc_mem[rd_ptr];
      q.pop_inst  = inst_mem[rd_ptr];
    end else if (bypass_c) begin
      q.pop_valid = 1'b1;
      q.pop_pc    = q.push_pc;
      q.pop_inst  = q.push_inst;
    end
  end

  // Pointer and occupancy state; reset beats flush beats push/pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (q.flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + AW'(1);
      if (do_read)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_write, do_read})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is not reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (rst_n && !q.flush && do_write) begin
      pc_mem[wr_ptr]   <= q.push_pc;
      inst_mem[wr_ptr] <= q.push_inst;
    end
  end

endmodule
